// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative CORDIC vectoring engine, atan2(y, x) in pdQp, one micro-rotation per clock.
// Define CORDIC_MAG_EN to add the o_mag magnitude output and its 1/K scaling multiplier.
module cordic_atan2 #(
    parameter int pd   = 4,
    parameter int p    = 22,
    parameter int ITER = 22
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [p+2:0]    i_x,
    input  logic signed [p+2:0]    i_y,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic signed [pd+p-1:0] o_angle,
    output logic                   o_valid,
    input  logic                   i_ready,
`ifdef CORDIC_MAG_EN
    output logic [pd+p-1:0]        o_mag,
`endif
    output logic                   o_zero
);

    // Constants are held in 4Q22 and truncated to the configured fraction width.
    function automatic longint q22_scale(input longint v);
        if (p >= 22) return v <<< (p - 22);
        return v >>> (22 - p);
    endfunction

    function automatic longint atan_q22(input int i);
        case (i)
            0:       return 64'sd3294199;
            1:       return 64'sd1944679;
            2:       return 64'sd1027515;
            3:       return 64'sd521583;
            4:       return 64'sd261803;
            5:       return 64'sd131029;
            6:       return 64'sd65531;
            7:       return 64'sd32767;
            8:       return 64'sd16384;
            9:       return 64'sd8192;
            default: return (i <= 22) ? (64'sd1 <<< (22 - i)) : 64'sd0;
        endcase
    endfunction

    localparam int W  = p + 6;
    localparam int AW = pd + p;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic signed [AW-1:0] PI_Q   = AW'(q22_scale(64'sd13176795));
    localparam logic signed [AW-1:0] PI_2_Q = AW'(q22_scale(64'sd6588397));

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

    state_t               state_reg;
    logic signed [W-1:0]  x_reg, y_reg;
    logic signed [AW-1:0] z_reg;
    logic [IW-1:0]        iter_reg;
    logic                 zero_reg;

    logic signed [AW-1:0] atan_lut [ITER];
    for (genvar gi = 0; gi < ITER; gi++) begin : g_lut
        assign atan_lut[gi] = AW'(q22_scale(atan_q22(gi)));
    end

    logic signed [W-1:0]  x_shift, y_shift, x_next, y_next;
    logic signed [AW-1:0] z_next, z_sat;

    // Both updates read the pre-iteration X and Y.
    always_comb begin
        x_shift = x_reg >>> iter_reg;
        y_shift = y_reg >>> iter_reg;
        if (!y_reg[W-1]) begin
            x_next = x_reg + y_shift;
            y_next = y_reg - x_shift;
            z_next = z_reg + atan_lut[iter_reg];
        end else begin
            x_next = x_reg - y_shift;
            y_next = y_reg + x_shift;
            z_next = z_reg - atan_lut[iter_reg];
        end
        z_sat = z_next;
        if (z_next > PI_Q)
            z_sat = PI_Q;
        else if (z_next < -PI_Q)
            z_sat = -PI_Q;
    end

`ifdef CORDIC_MAG_EN
    localparam logic [AW-1:0] INV_K = AW'(q22_scale(64'sd2547003));
    logic [W+AW-1:0] mag_prod;
    assign mag_prod = {{AW{1'b0}}, x_next} * {{W{1'b0}}, INV_K};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            zero_reg  <= 1'b0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_angle   <= '0;
            o_zero    <= 1'b0;
`ifdef CORDIC_MAG_EN
            o_mag     <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        x_reg     <= {{3{i_x[p+2]}}, i_x};
                        y_reg     <= {{3{i_y[p+2]}}, i_y};
                        zero_reg  <= (i_x == '0) && (i_y == '0);
                        o_ready   <= 1'b0;
                        state_reg <= S_PRE;
                    end
                end
                S_PRE: begin
                    // Fold the left half-plane into the right so the iterations converge.
                    if (!x_reg[W-1]) begin
                        z_reg <= '0;
                    end else if (!y_reg[W-1]) begin
                        x_reg <= y_reg;
                        y_reg <= -x_reg;
                        z_reg <= PI_2_Q;
                    end else begin
                        x_reg <= -y_reg;
                        y_reg <= x_reg;
                        z_reg <= -PI_2_Q;
                    end
                    iter_reg  <= '0;
                    state_reg <= S_ITER;
                end
                S_ITER: begin
                    x_reg <= x_next;
                    y_reg <= y_next;
                    z_reg <= z_next;
                    if (iter_reg == IW'(ITER - 1)) begin
                        o_valid   <= 1'b1;
                        o_angle   <= zero_reg ? '0 : z_sat;
                        o_zero    <= zero_reg;
`ifdef CORDIC_MAG_EN
                        o_mag     <= zero_reg ? '0 : AW'(mag_prod >> p);
`endif
                        state_reg <= S_DONE;
                    end else begin
                        iter_reg <= iter_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        o_ready   <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan2.sv
// tb_cordic_atan2: directed and random checks of cordic_atan2 through an expected-result queue.
// Connects o_mag and checks magnitude when CORDIC_MAG_EN is defined.
`timescale 1ns/1ps
module tb_cordic_atan2;

    localparam int P    = 22;
    localparam int PD   = 4;
    localparam int ITER = 22;
    localparam int AW   = PD + P;
    localparam longint PI_Q = 64'sd13176795;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [P+2:0]  i_x = '0;
    logic signed [P+2:0]  i_y = '0;
    logic                 i_valid = 1'b0;
    logic                 i_ready = 1'b1;
    logic                 o_ready, o_valid, o_zero;
    logic signed [AW-1:0] o_angle;
`ifdef CORDIC_MAG_EN
    logic [AW-1:0]        o_mag;
`endif

    int     n_vec = 0;
    int     n_bad = 0;
    longint cyc = 0;

    typedef struct {
        string  tag;
        longint ang;
        int     tol;
        bit     wrap;
        bit     zero;
        longint mag;
        int     mtol;
    } exp_t;

    exp_t sb[$];

    cordic_atan2 #(.pd(PD), .p(P), .ITER(ITER)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_angle (o_angle),
        .o_valid (o_valid),
        .i_ready (i_ready),
`ifdef CORDIC_MAG_EN
        .o_mag   (o_mag),
`endif
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input string tag, input longint ang, input int tol, input bit wrap,
                                input bit zero, input longint mag, input int mtol);
        exp_t e;
        e.tag  = tag;
        e.ang  = ang;
        e.tol  = tol;
        e.wrap = wrap;
        e.zero = zero;
        e.mag  = mag;
        e.mtol = mtol;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string tag, input longint obs, input longint req);
        n_vec++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, req);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint req, input int tol, input bit wrap);
        longint d;
        d = obs - req;
        if (wrap) begin
            if (d > PI_Q) d = d - 2 * PI_Q;
            else if (d < -PI_Q) d = d + 2 * PI_Q;
        end
        if (d < 0) d = -d;
        n_vec++;
        assert ((d <= longint'(tol)) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d +/- %0d", tag, obs, req, tol);
        end
    endtask

    task automatic send(input longint x, input longint y, output longint acc);
        int w;
        w = 0;
        while (o_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk_eq("ready_before_send", longint'(o_ready), 1);
        i_x     = (P+3)'(x);
        i_y     = (P+3)'(y);
        i_valid = 1'b1;
        tick();
        acc     = cyc;
        i_valid = 1'b0;
    endtask

    task automatic collect(input longint acc);
        exp_t e;
        int   w;
        w = 0;
        while (o_valid !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        chk_eq("valid_seen", longint'(o_valid), 1);
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: got output, want no pending entry");
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        if (o_valid === 1'b1) begin
            // Latency counts rising edges from the accept edge through the first edge showing o_valid.
            chk_eq({e.tag, "_latency"}, cyc - acc + 1, longint'(ITER + 2));
            chk_tol({e.tag, "_angle"}, longint'(o_angle), e.ang, e.tol, e.wrap);
            chk_eq({e.tag, "_zero"}, longint'(o_zero), longint'(e.zero));
`ifdef CORDIC_MAG_EN
            chk_tol({e.tag, "_mag"}, longint'(o_mag), e.mag, e.mtol, 1'b0);
`endif
        end
        if (i_ready) tick();
    endtask

    initial begin
        longint              acc;
        logic signed [P+2:0] rx, ry;
        longint              lx, ly, ang, mag;
        real                 xr, yr;

        rst_n = 1'b0;
        tick();
        tick();
        chk_eq("rst_ready", longint'(o_ready), 1);
        chk_eq("rst_valid", longint'(o_valid), 0);
        chk_eq("rst_angle", longint'(o_angle), 0);
        chk_eq("rst_zero", longint'(o_zero), 0);
`ifdef CORDIC_MAG_EN
        chk_eq("rst_mag", longint'(o_mag), 0);
`endif
        rst_n = 1'b1;
        tick();

        // (1.0, 0) -> 0
        sb.push_back(mk("pos_x", 0, 16, 1'b0, 1'b0, 4194304, 16));
        send(4194304, 0, acc);
        collect(acc);

        // (0, 1.0) -> +pi/2, (-1.0, 0) -> +pi
        sb.push_back(mk("pos_y", 6588397, 16, 1'b0, 1'b0, 4194304, 16));
        send(0, 4194304, acc);
        collect(acc);
        sb.push_back(mk("neg_x", 13176795, 16, 1'b0, 1'b0, 4194304, 16));
        send(-4194304, 0, acc);
        collect(acc);

        // (1.0, -1.0) -> -pi/4, magnitude sqrt2
        sb.push_back(mk("m_pi4", -3294199, 16, 1'b0, 1'b0, 5931642, 16));
        send(4194304, -4194304, acc);
        collect(acc);

        // Zero vector, then a normal one clears o_zero
        sb.push_back(mk("zero", 0, 0, 1'b0, 1'b1, 0, 0));
        send(0, 0, acc);
        collect(acc);
        sb.push_back(mk("after_zero", 0, 16, 1'b0, 1'b0, 4194304, 16));
        send(4194304, 0, acc);
        collect(acc);

        // Full-scale corner (-4.0, -4.0) -> -3pi/4, magnitude 4*sqrt2
        sb.push_back(mk("full_scale", -9882596, 16, 1'b0, 1'b0, 23726566, 16));
        send(-16777216, -16777216, acc);
        collect(acc);

        // Backpressure in DONE with ignored i_valid pulses
        sb.push_back(mk("bp", -6588397, 16, 1'b0, 1'b0, 4194304, 16));
        send(0, -4194304, acc);
        i_ready = 1'b0;
        collect(acc);
        for (int k = 0; k < 10; k++) begin
            i_valid = (k % 2 == 0);
            i_x     = 25'sd4194304;
            i_y     = 25'sd4194304;
            tick();
            chk_eq("bp_valid_hold", longint'(o_valid), 1);
            chk_eq("bp_ready_low", longint'(o_ready), 0);
            chk_tol("bp_angle_hold", longint'(o_angle), -6588397, 16, 1'b0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk_eq("bp_valid_drop", longint'(o_valid), 0);
        chk_eq("bp_ready_back", longint'(o_ready), 1);
        repeat (30) tick();
        chk_eq("bp_no_ghost", longint'(o_valid), 0);

        // Reset during iteration 5 aborts the sample
        send(4194304, 4194304, acc);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("abort_ready", longint'(o_ready), 1);
        chk_eq("abort_valid", longint'(o_valid), 0);
        chk_eq("abort_angle", longint'(o_angle), 0);
        chk_eq("abort_zero", longint'(o_zero), 0);
`ifdef CORDIC_MAG_EN
        chk_eq("abort_mag", longint'(o_mag), 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        sb.push_back(mk("after_abort", 3294199, 16, 1'b0, 1'b0, 5931642, 16));
        send(4194304, 4194304, acc);
        collect(acc);

        // Random sweep against a real-valued model
        for (int k = 0; k < 1000; k++) begin
            do begin
                rx = (P+3)'($urandom);
                ry = (P+3)'($urandom);
                lx = longint'(rx);
                ly = longint'(ry);
            end while (lx * lx + ly * ly < 2 * (64'sd1 <<< 44));
            xr  = real'(lx) / 4194304.0;
            yr  = real'(ly) / 4194304.0;
            ang = longint'($atan2(yr, xr) * 4194304.0);
            mag = longint'($sqrt(xr * xr + yr * yr) * 4194304.0);
            sb.push_back(mk("rnd", ang, 16, 1'b1, 1'b0, mag, 16));
            send(lx, ly, acc);
            collect(acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
